// File: rtl/ttc_pkg.sv
// ---------------------------------------------------------------------------
// ttc_pkg
// Shared definitions for the TTC receive-side frame decoder.
//   TTC_IDLE_SYM / TTC_START_SYM : line symbols with fixed meaning
//   ttc_state_t                  : deframer state
//   ttc_cmd_t                    : the four command bits carried by a frame
//   ttc_cmd_par()                : odd-parity bit expected in the PAR slot
// ---------------------------------------------------------------------------
package ttc_pkg;

    localparam logic [1:0] TTC_IDLE_SYM  = 2'b00;
    localparam logic [1:0] TTC_START_SYM = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYM1 = 2'b01,
        SYM2 = 2'b10,
        PAR  = 2'b11
    } ttc_state_t;

    typedef struct packed {
        logic trig;
        logic bcr;
        logic evr;
        logic mr;
    } ttc_cmd_t;

    localparam ttc_cmd_t TTC_CMD_NONE = ttc_cmd_t'(4'b0000);

    // Odd parity over the command bits: the frame carries ~^{trig,bcr,evr,mr}.
    function automatic logic ttc_cmd_par(input ttc_cmd_t cmd);
        return ~(^cmd);
    endfunction

endpackage

// File: rtl/ttc_bunch_counter.sv
// ---------------------------------------------------------------------------
// ttc_bunch_counter
// Free-running bunch-crossing counter. Counts 0..BC_ROLLOVER and wraps to 0;
// a load request replaces the next value with BCR_OFFSET.
// Ports:
//   clk        in   1           clock
//   rst        in   1           synchronous reset, active-high (counter -> 0)
//   load       in   1           next value = BCR_OFFSET
//   bcid_next  out  BCID_WIDTH  value the counter takes at the coming edge
//                               (i.e. the BCID of the following cycle)
// ---------------------------------------------------------------------------
module ttc_bunch_counter #(
    parameter int BCID_WIDTH  = 12,
    parameter int BC_ROLLOVER = 3563,
    parameter int BCR_OFFSET  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    output logic [BCID_WIDTH-1:0] bcid_next
);

    localparam logic [BCID_WIDTH-1:0] ROLL_C = BCID_WIDTH'(BC_ROLLOVER);
    localparam logic [BCID_WIDTH-1:0] OFFS_C = BCID_WIDTH'(BCR_OFFSET);
    localparam logic [BCID_WIDTH-1:0] ONE_C  = BCID_WIDTH'(1);
    localparam logic [BCID_WIDTH-1:0] ZERO_C = {BCID_WIDTH{1'b0}};

    logic [BCID_WIDTH-1:0] bcid_r;
    logic [BCID_WIDTH-1:0] bcid_next_s;

    // Next-count selection: offset load wins over rollover and increment.
    always_comb begin
        bcid_next_s = bcid_r;
        if (load) begin
            bcid_next_s = OFFS_C;
        end else if (bcid_r == ROLL_C) begin
            bcid_next_s = ZERO_C;
        end else begin
            bcid_next_s = bcid_r + ONE_C;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcid_r <= ZERO_C;
        end else begin
            bcid_r <= bcid_next_s;
        end
    end

    assign bcid_next = bcid_next_s;

endmodule

// File: rtl/ttc_frame_decoder.sv
// ---------------------------------------------------------------------------
// ttc_frame_decoder
// Deframes the 2-bit/cycle TTC symbol stream (start, {trig,bcr}, {evr,mr},
// {par,stop}) and emits registered one-cycle command pulses. Keeps the
// BCID/EVID counters and tags each trigger with their values in the trigger
// cycle. Bad parity/stop or a stray non-idle symbol in IDLE raises frame_err
// and drops the frame's commands.
// Optional feature: define TTC_ERR_CNT_EN to get a saturating error counter
// on err_count; otherwise err_count is constant 0.
// Ports:
//   clk_40        in   1           40 MHz clock
//   rst_40        in   1           synchronous reset, active-high
//   encode_ttc    in   2           symbol stream, one symbol per clock
//   trigger       out  1           decoded L1 trigger pulse
//   bc_reset      out  1           decoded bunch-counter reset pulse
//   event_reset   out  1           decoded event-counter reset pulse
//   master_reset  out  1           decoded master reset pulse
//   trig_bcid     out  BCID_WIDTH  BCID tag, valid with trigger
//   trig_evid     out  EVID_WIDTH  EVID tag, valid with trigger
//   frame_err     out  1           frame error pulse
//   err_count     out  8           saturating error count
// ---------------------------------------------------------------------------
module ttc_frame_decoder
    import ttc_pkg::*;
#(
    parameter int BCID_WIDTH  = 12,
    parameter int BC_ROLLOVER = 3563,
    parameter int BCR_OFFSET  = 0,
    parameter int EVID_WIDTH  = 12
) (
    input  logic                  clk_40,
    input  logic                  rst_40,
    input  logic [1:0]            encode_ttc,
    output logic                  trigger,
    output logic                  bc_reset,
    output logic                  event_reset,
    output logic                  master_reset,
    output logic [BCID_WIDTH-1:0] trig_bcid,
    output logic [EVID_WIDTH-1:0] trig_evid,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam logic [EVID_WIDTH-1:0] EVID_ONE_C  = EVID_WIDTH'(1);
    localparam logic [EVID_WIDTH-1:0] EVID_ZERO_C = {EVID_WIDTH{1'b0}};
    localparam logic [BCID_WIDTH-1:0] BCID_ZERO_C = {BCID_WIDTH{1'b0}};

    ttc_state_t            state_r;
    ttc_state_t            state_next_s;
    ttc_cmd_t              cmd_r;
    ttc_cmd_t              cmd_next_s;
    ttc_cmd_t              pulse_next_s;
    logic                  err_next_s;

    logic                  trigger_r;
    logic                  bc_reset_r;
    logic                  event_reset_r;
    logic                  master_reset_r;
    logic                  frame_err_r;
    logic [BCID_WIDTH-1:0] trig_bcid_r;
    logic [EVID_WIDTH-1:0] trig_evid_r;
    logic [EVID_WIDTH-1:0] evid_r;
    logic [EVID_WIDTH-1:0] evid_next_s;
    logic [BCID_WIDTH-1:0] bcid_next_s;
    logic                  bc_load_s;

    // FSM state register.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: the start symbol only counts in IDLE, data slots are
    // taken unconditionally so 2'b11 there is ordinary data.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (encode_ttc == TTC_START_SYM) begin
                    state_next_s = SYM1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SYM1:    state_next_s = SYM2;
            SYM2:    state_next_s = PAR;
            PAR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: command-bit capture, then frame check in the PAR slot.
    always_comb begin
        cmd_next_s   = cmd_r;
        pulse_next_s = TTC_CMD_NONE;
        err_next_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_next_s = TTC_CMD_NONE;
                if ((encode_ttc != TTC_IDLE_SYM) && (encode_ttc != TTC_START_SYM)) begin
                    err_next_s = 1'b1;
                end else begin
                    err_next_s = 1'b0;
                end
            end
            SYM1: begin
                cmd_next_s.trig = encode_ttc[1];
                cmd_next_s.bcr  = encode_ttc[0];
            end
            SYM2: begin
                cmd_next_s.evr = encode_ttc[1];
                cmd_next_s.mr  = encode_ttc[0];
            end
            PAR: begin
                if ((encode_ttc[1] == ttc_cmd_par(cmd_r)) && (encode_ttc[0] == 1'b0)) begin
                    pulse_next_s = cmd_r;
                end else begin
                    err_next_s = 1'b1;
                end
            end
            default: begin
                cmd_next_s = TTC_CMD_NONE;
            end
        endcase
    end

    // Command capture and registered pulse outputs.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            cmd_r          <= TTC_CMD_NONE;
            trigger_r      <= 1'b0;
            bc_reset_r     <= 1'b0;
            event_reset_r  <= 1'b0;
            master_reset_r <= 1'b0;
            frame_err_r    <= 1'b0;
        end else begin
            cmd_r          <= cmd_next_s;
            trigger_r      <= pulse_next_s.trig;
            bc_reset_r     <= pulse_next_s.bcr;
            event_reset_r  <= pulse_next_s.evr;
            master_reset_r <= pulse_next_s.mr;
            frame_err_r    <= err_next_s;
        end
    end

    // A bc_reset or master_reset pulse loads the offset at the end of its cycle.
    assign bc_load_s = bc_reset_r | master_reset_r;

    ttc_bunch_counter #(
        .BCID_WIDTH  (BCID_WIDTH),
        .BC_ROLLOVER (BC_ROLLOVER),
        .BCR_OFFSET  (BCR_OFFSET)
    ) u_bunch_counter (
        .clk       (clk_40),
        .rst       (rst_40),
        .load      (bc_load_s),
        .bcid_next (bcid_next_s)
    );

    // EVID next value: any reset pulse clears it (and beats the increment).
    always_comb begin
        evid_next_s = evid_r;
        if (master_reset_r || event_reset_r) begin
            evid_next_s = EVID_ZERO_C;
        end else if (trigger_r) begin
            evid_next_s = evid_r + EVID_ONE_C;
        end else begin
            evid_next_s = evid_r;
        end
    end

    // EVID counter register.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            evid_r <= EVID_ZERO_C;
        end else begin
            evid_r <= evid_next_s;
        end
    end

    // Trigger tags: the counters' next values are exactly what they hold
    // during the trigger pulse cycle, so register those alongside the pulse.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            trig_bcid_r <= BCID_ZERO_C;
            trig_evid_r <= EVID_ZERO_C;
        end else if (pulse_next_s.trig) begin
            trig_bcid_r <= bcid_next_s;
            trig_evid_r <= evid_next_s;
        end else begin
            trig_bcid_r <= trig_bcid_r;
            trig_evid_r <= trig_evid_r;
        end
    end

`ifdef TTC_ERR_CNT_EN
    logic [7:0] err_count_r;

    // Saturating frame-error counter, cleared by a decoded master reset.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            err_count_r <= 8'h00;
        end else if (master_reset_r) begin
            err_count_r <= 8'h00;
        end else if (frame_err_r && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'h01;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = 8'h00;
`endif

    assign trigger      = trigger_r;
    assign bc_reset     = bc_reset_r;
    assign event_reset  = event_reset_r;
    assign master_reset = master_reset_r;
    assign frame_err    = frame_err_r;
    assign trig_bcid    = trig_bcid_r;
    assign trig_evid    = trig_evid_r;

endmodule

// File: tb/tb_ttc_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_ttc_frame_decoder
// Scoreboard bench: the driver pushes the expected output event of every
// frame / stray symbol; a negedge monitor pops and compares whenever any
// pulse output is high. BCID is modelled arithmetically from the last load
// point, EVID as a trigger count since the last clear.
// ---------------------------------------------------------------------------
module tb_ttc_frame_decoder;

    localparam int ROLL   = 3563;
    localparam int OFFS   = 0;
    localparam int BC_MOD = ROLL + 1;

    logic        clk_40     = 1'b0;
    logic        rst_40     = 1'b1;
    logic [1:0]  encode_ttc = 2'b00;
    logic        trigger, bc_reset, event_reset, master_reset, frame_err;
    logic [11:0] trig_bcid, trig_evid;
    logic [7:0]  err_count;

    ttc_frame_decoder #(
        .BCID_WIDTH  (12),
        .BC_ROLLOVER (ROLL),
        .BCR_OFFSET  (OFFS),
        .EVID_WIDTH  (12)
    ) dut (
        .clk_40       (clk_40),
        .rst_40       (rst_40),
        .encode_ttc   (encode_ttc),
        .trigger      (trigger),
        .bc_reset     (bc_reset),
        .event_reset  (event_reset),
        .master_reset (master_reset),
        .trig_bcid    (trig_bcid),
        .trig_evid    (trig_evid),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    always #5 clk_40 = ~clk_40;

    // Edge index: after posedge k, cyc == k.
    int cyc = 0;
    always @(posedge clk_40) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        trig, bcr, evr, mr, err;
        logic [11:0] tb, te;
        logic [7:0]  ec;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int          anchor_cyc = 0;  // edge after which BCID == anchor_val
    int          anchor_val = 0;
    int          evid_m     = 0;
    int          ecnt_m     = 0;
    logic [11:0] tag_b      = 12'd0;
    logic [11:0] tag_e      = 12'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bcid_at(input int c);
        return (anchor_val + (c - anchor_cyc)) % BC_MOD;
    endfunction

    function automatic void count_err();
`ifdef TTC_ERR_CNT_EN
        if (ecnt_m < 255) ecnt_m++;
`endif
    endfunction

    // Monitor: any pulse output consumes one scoreboard entry.
    always @(negedge clk_40) begin
        exp_t x;
        if (trigger | bc_reset | event_reset | master_reset | frame_err) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {27'd0, trigger, bc_reset, event_reset, master_reset, frame_err}, 32'd0);
            end else begin
                x = q.pop_front();
                chk("pulse_cycle", cyc, x.cyc);
                chk("trigger", {31'd0, trigger}, {31'd0, x.trig});
                chk("bc_reset", {31'd0, bc_reset}, {31'd0, x.bcr});
                chk("event_reset", {31'd0, event_reset}, {31'd0, x.evr});
                chk("master_reset", {31'd0, master_reset}, {31'd0, x.mr});
                chk("frame_err", {31'd0, frame_err}, {31'd0, x.err});
                chk("trig_bcid", {20'd0, trig_bcid}, {20'd0, x.tb});
                chk("trig_evid", {20'd0, trig_evid}, {20'd0, x.te});
                chk("err_count", {24'd0, err_count}, {24'd0, x.ec});
            end
        end
    end

    task automatic send_sym(input logic [1:0] s);
        encode_ttc = s;
        @(posedge clk_40);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_sym(2'b00);
    endtask

    // badm: 0 good, 1 wrong parity, 2 stop bit set
    task automatic send_frame(input logic t, input logic b, input logic e, input logic m, input int badm);
        exp_t x;
        logic p;
        int   pc;
        p = ~(t ^ b ^ e ^ m);
        send_sym(2'b11);
        pc    = cyc + 3;
        x.cyc = pc;
        x.trig = 1'b0; x.bcr = 1'b0; x.evr = 1'b0; x.mr = 1'b0; x.err = 1'b0;
        x.ec  = 8'(ecnt_m);
        if (badm == 0) begin
            x.trig = t; x.bcr = b; x.evr = e; x.mr = m;
            if (t) begin
                tag_b = 12'(bcid_at(pc));
                tag_e = 12'(evid_m);
            end
            if (m) begin
                evid_m = 0; ecnt_m = 0;
                anchor_cyc = pc + 1; anchor_val = OFFS;
            end else begin
                if (e) evid_m = 0;
                else if (t) evid_m = (evid_m + 1) % 4096;
                if (b) begin anchor_cyc = pc + 1; anchor_val = OFFS; end
            end
        end else begin
            x.err = 1'b1;
            count_err();
        end
        x.tb = tag_b;
        x.te = tag_e;
        if (x.trig | x.bcr | x.evr | x.mr | x.err) q.push_back(x);
        send_sym({t, b});
        send_sym({e, m});
        if (badm == 1)      send_sym({~p, 1'b0});
        else if (badm == 2) send_sym({p, 1'b1});
        else                send_sym({p, 1'b0});
    endtask

    task automatic send_stray(input logic [1:0] s);
        exp_t x;
        send_sym(s);
        x.cyc = cyc;
        x.trig = 1'b0; x.bcr = 1'b0; x.evr = 1'b0; x.mr = 1'b0; x.err = 1'b1;
        x.tb = tag_b; x.te = tag_e; x.ec = 8'(ecnt_m);
        count_err();
        q.push_back(x);
    endtask

    task automatic apply_reset();
        rst_40 = 1'b1;
        idle(2);
        anchor_cyc = cyc; anchor_val = 0;
        evid_m = 0; ecnt_m = 0; tag_b = 12'd0; tag_e = 12'd0;
        rst_40 = 1'b0;
        chk("rst_pulses", {27'd0, trigger, bc_reset, event_reset, master_reset, frame_err}, 32'd0);
        chk("rst_trig_bcid", {20'd0, trig_bcid}, 32'd0);
        chk("rst_trig_evid", {20'd0, trig_evid}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        apply_reset();
        idle(3);
        // trig-only frames: EVID 0 then 1
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(2);
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(2);
        // bc_reset, then a tagged trigger shortly after
        send_frame(1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(1);
        // bad parity and stray symbol
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 1);
        idle(1);
        send_stray(2'b01);
        idle(1);
        chk("err_count_after_errors", {24'd0, err_count}, ecnt_m);
        // back-to-back triggers
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        // master reset, five triggers to EVID=5, trig+evr, next trigger tagged 0
        send_frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        send_frame(1'b1, 1'b0, 1'b1, 1'b0, 0);
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        // BCID rollover: idle past a full orbit, then tag a trigger
        idle(3600);
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        // reset in the middle of a frame is silent
        send_sym(2'b11);
        send_sym(2'b10);
        apply_reset();
        idle(2);
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2));
            kind = $urandom_range(0, 9);
            if (kind == 0)
                send_stray(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
            else
                send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           (kind == 1) ? 1 : (kind == 2) ? 2 : 0);
        end
        idle(8);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
